pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline control unit for the five-stage MIPS core. Arbitrates stall requests from ID, EX and MEM into the six-bit stall vector (bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB) consumed by every pipeline register. Sequences exception recovery by driving flush and the redirect PC for a programmable number of cycles. Keeps stall/flush statistics and a stuck-stall watchdog.

## Interface
- FLUSH_CYCLES, 2: cycles flush_o stays high per exception (≥1).
- EXC_VECTOR, 32'h00000020: redirect PC for all exceptions except ERET.
- TIMEOUT, 1024: consecutive stall cycles that trip the watchdog (≥2, <2^16).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stallreq_id  in  1  ID stage requests stall (load-use hazard).
- stallreq_ex  in  1  EX stage requests stall (multi-cycle mul/div).
- stallreq_mem  in  1  MEM stage requests stall (bus wait).
- excepttype_i  in  32  committed exception type from MEM; 0 = none, 32'h0000000e = ERET.
- cp0_epc_i  in  32  current EPC from CP0.
- clr_stats_i  in  1  synchronous clear of statistics and watchdog flag.
- stall_o  out  6  stall vector.
- flush_o  out  1  flush all pipeline registers.
- new_pc_o  out  32  redirect PC, valid while flush_o=1.
- stall_cycles_o  out  32  cycles with stall_o≠0, wraps at 2^32.
- flush_count_o  out  16  exceptions taken, saturates at 16'hFFFF.
- stall_timeout_o  out  1  sticky watchdog flag.

## Operation
- States: RUN, FLUSH. Counter fcnt (width ≥ clog2(FLUSH_CYCLES+1)), run-length counter slen (16 bit, saturating).
- RUN, excepttype_i≠0: flush_o=1 combinationally this cycle, stall_o=0. new_pc_o = cp0_epc_i if excepttype_i=32'h0000000e, else EXC_VECTOR. The PC is also latched into pc_q. If FLUSH_CYCLES>1, go to FLUSH with fcnt=FLUSH_CYCLES-1; otherwise stay in RUN. flush_count_o increments (saturating).
- FLUSH: flush_o=1, new_pc_o=pc_q, stall_o=0. Ignore excepttype_i and all stall requests. Decrement fcnt; when fcnt reaches 1, return to RUN next edge.
- RUN, no exception, stall priority (highest wins): stallreq_mem → 6'b011111; else stallreq_ex → 6'b001111; else stallreq_id → 6'b000111; else 6'b000000. Exception beats every stall request.
- new_pc_o = 0 whenever flush_o=0.
- stall_cycles_o increments on each edge where stall_o≠0.
- slen increments on each edge with stall_o≠0 and clears to 0 on any edge with stall_o=0. When slen+1 == TIMEOUT, set stall_timeout_o; it stays set until reset or clr_stats_i.
- clr_stats_i zeroes stall_cycles_o, flush_count_o, slen and stall_timeout_o on the next edge. It has priority over same-cycle increments. It does not affect the FSM, fcnt or pc_q.

## Timing
- Reset (asynchronous): state=RUN, fcnt=0, pc_q=0, slen=0. Outputs: stall_o=0, flush_o=0, new_pc_o=0, stall_cycles_o=0, flush_count_o=0, stall_timeout_o=0.
- Stall and first flush cycle are combinational from inputs, zero latency, so pipeline registers react on the same edge.
- Flush pulse length is exactly FLUSH_CYCLES cycles. The earliest next exception is accepted FLUSH_CYCLES cycles after the previous one.
- A stall request held during FLUSH takes effect on the first RUN cycle.
- Reset asserted mid-FLUSH: flush_o drops immediately, with no completion of the sequence.
- Statistics update one edge after the qualifying cycle.

## Test plan
- Reset, then stallreq_ex=1 and stallreq_id=1 together → stall_o=6'b001111. Add stallreq_mem → 6'b011111. Release all → 6'b000000, stall_cycles_o=2.
- excepttype_i=32'h00000008 for one cycle with stallreq_mem=1 (FLUSH_CYCLES=2) → flush_o=1 for 2 cycles, new_pc_o=32'h20 both cycles, stall_o=0 both, flush_count_o=1. Then stall_o=6'b011111 if stallreq_mem is still high.
- excepttype_i=32'h0000000e, cp0_epc_i=32'hBFC00100, then cp0_epc_i changes during FLUSH → new_pc_o stays 32'hBFC00100 for both flush cycles.
- Second exception presented during FLUSH → ignored, flush ends on schedule, flush_count_o=1.
- TIMEOUT=8, stallreq_id held 8 cycles → stall_timeout_o=1 after the 8th edge and stays 1 after release. clr_stats_i pulse → stall_timeout_o=0, stall_cycles_o=0. Also check 7-cycle stall, gap, 7-cycle stall → no timeout.
- Async rst asserted between clock edges mid-FLUSH → flush_o, new_pc_o and all counters read 0 immediately, and state returns to RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - MIPS pipeline stall arbitration, exception flush sequencer, stall statistics
module pipe_ctrl #(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
    parameter int          TIMEOUT      = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        clr_stats_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_count_o,
    output logic        stall_timeout_o
);

    localparam int          FCW      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [31:0] EXC_ERET = 32'h0000000e;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [FCW-1:0]   r_fcnt;
    logic [FCW-1:0]   w_fcnt_nxt;
    logic [31:0]      r_pc_q;
    logic [31:0]      w_pc_nxt;
    logic [15:0]      r_slen;
    logic [31:0]      r_stall_cycles;
    logic [15:0]      r_flush_count;
    logic             r_timeout;

    logic [5:0]       w_stall;
    logic             w_flush;
    logic [31:0]      w_new_pc;
    logic             w_exc_taken;
    logic             w_stall_any;
    logic [16:0]      w_slen_inc;

    assign w_exc_taken = (r_state == ST_RUN) && (excepttype_i != 32'd0);
    assign w_stall_any = (w_stall != 6'd0);
    assign w_slen_inc  = {1'b0, r_slen} + 17'd1;

    // FSM state, flush countdown and latched redirect PC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_fcnt  <= '0;
            r_pc_q  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_pc_q  <= w_pc_nxt;
        end
    end

    // Next state plus zero-latency stall/flush/redirect outputs
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_pc_nxt    = r_pc_q;
        w_stall     = 6'b000000;
        w_flush     = 1'b0;
        w_new_pc    = 32'd0;
        case (r_state)
            ST_RUN: begin
                if (excepttype_i != 32'd0) begin
                    // Exception wins over every stall request
                    w_flush  = 1'b1;
                    w_new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
                    w_pc_nxt = w_new_pc;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt = ST_FLUSH;
                        w_fcnt_nxt  = FCW'(FLUSH_CYCLES - 1);
                    end
                end else if (stallreq_mem) begin
                    w_stall = 6'b011111;
                end else if (stallreq_ex) begin
                    w_stall = 6'b001111;
                end else if (stallreq_id) begin
                    w_stall = 6'b000111;
                end
            end
            ST_FLUSH: begin
                // Exceptions and stall requests are ignored until the flush completes
                w_flush    = 1'b1;
                w_new_pc   = r_pc_q;
                w_fcnt_nxt = r_fcnt - FCW'(1);
                if (r_fcnt == FCW'(1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Statistics and stuck-stall watchdog; clear beats same-cycle increments
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slen         <= 16'd0;
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 16'd0;
            r_timeout      <= 1'b0;
        end else if (clr_stats_i) begin
            r_slen         <= 16'd0;
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 16'd0;
            r_timeout      <= 1'b0;
        end else begin
            if (w_stall_any) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
                if (r_slen != 16'hFFFF) begin
                    r_slen <= r_slen + 16'd1;
                end
                if (w_slen_inc == 17'(TIMEOUT)) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_slen <= 16'd0;
            end
            if (w_exc_taken && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign stall_o         = w_stall;
    assign flush_o         = w_flush;
    assign new_pc_o        = w_new_pc;
    assign stall_cycles_o  = r_stall_cycles;
    assign flush_count_o   = r_flush_count;
    assign stall_timeout_o = r_timeout;

endmodule
